// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: per-channel half-period and square/pulse mode.
// Each channel counts 0..N-1 and acts on the wrap.
module prog_clock_divider #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CNT_W    = 27,
    parameter int unsigned DEF_HALF = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   ch_en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [3:0]       wr_ch,
    input  logic [CNT_W-1:0] wr_half,
    input  logic             wr_mode,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    logic [CNT_W-1:0] half_q [NCH];
    logic [CNT_W-1:0] cnt_q  [NCH];
    logic [NCH-1:0]   mode_q;
    logic             wr_valid;
    logic [NCH-1:0]   wr_hit;

    assign wr_valid = wr_en && (32'(wr_ch) < NCH);

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = wr_valid && (32'(wr_ch) == i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                half_q[i] <= CNT_W'(DEF_HALF);
                cnt_q[i]  <= '0;
            end
            mode_q  <= '0;
            clk_out <= '0;
            tick    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_hit[i]) begin
                    // A write restarts its channel and suppresses any coincident terminal event.
                    half_q[i]  <= wr_half;
                    mode_q[i]  <= wr_mode;
                    cnt_q[i]   <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else if (sync || !ch_en[i] || (half_q[i] == '0)) begin
                    cnt_q[i]   <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else if (cnt_q[i] == half_q[i] - CNT_W'(1)) begin
                    cnt_q[i] <= '0;
                    if (mode_q[i]) begin
                        clk_out[i] <= 1'b1;
                        tick[i]    <= 1'b1;
                    end else begin
                        // Tick only on the 0->1 toggle.
                        clk_out[i] <= ~clk_out[i];
                        tick[i]    <= ~clk_out[i];
                    end
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    tick[i]  <= 1'b0;
                    if (mode_q[i]) begin
                        clk_out[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider (NCH=4, CNT_W=8, DEF_HALF=5).
// Expected outputs come from closed-form period formulas over edges-since-restart.
module tb_prog_clock_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ch_en = 4'h0;
    logic       sync = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_ch = 4'h0;
    logic [7:0] wr_half = 8'h0;
    logic       wr_mode = 1'b0;
    logic [3:0] clk_out;
    logic [3:0] tick;

    int n_checks = 0;
    int n_errors = 0;

    int mh [4];
    bit mm [4];
    int mk [4];

    prog_clock_divider #(
        .NCH      (4),
        .CNT_W    (8),
        .DEF_HALF (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ch_en   (ch_en),
        .sync    (sync),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_half (wr_half),
        .wr_mode (wr_mode),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {out, tick} for a channel k edges after its restart.
    function automatic logic [1:0] exp_bits(input int n, input bit m, input int k);
        logic o;
        logic t;
        if (n == 0 || k == 0) begin
            o = 1'b0;
            t = 1'b0;
        end else if (m) begin
            o = (k % n == 0);
            t = o;
        end else begin
            o = ((k / n) % 2 == 1);
            t = (k % (2 * n) == n);
        end
        return {o, t};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mh[i] = 5;
            mm[i] = 1'b0;
            mk[i] = 0;
        end
    endtask

    function automatic logic [7:0] exp_vec();
        logic [3:0] o;
        logic [3:0] t;
        logic [1:0] b;
        for (int i = 0; i < 4; i++) begin
            b    = exp_bits(mh[i], mm[i], mk[i]);
            o[i] = b[1];
            t[i] = b[0];
        end
        return {o, t};
    endfunction

    task automatic step(input string tag);
        logic [7:0] e;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_ch < 4 && int'(wr_ch) == i) begin
                mh[i] = int'(wr_half);
                mm[i] = wr_mode;
                mk[i] = 0;
            end else if (sync || !ch_en[i] || mh[i] == 0) begin
                mk[i] = 0;
            end else begin
                mk[i]++;
            end
        end
        #1;
        wr_en = 1'b0;
        sync  = 1'b0;
        e = exp_vec();
        check({tag, ".clk_out"}, 32'(clk_out), 32'(e[7:4]));
        check({tag, ".tick"}, 32'(tick), 32'(e[3:0]));
    endtask

    task automatic steps(input string tag, input int n);
        for (int j = 0; j < n; j++) step(tag);
    endtask

    task automatic write(input int ch, input int half, input bit mode);
        wr_en   = 1'b1;
        wr_ch   = 4'(ch);
        wr_half = 8'(half);
        wr_mode = mode;
    endtask

    initial begin
        logic [7:0] e;
        int guard;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("rst_async.clk_out", 32'(clk_out), 32'h0);
        check("rst_async.tick", 32'(tick), 32'h0);
        ch_en = 4'hF;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        steps("sq5", 25);

        write(1, 3, 1'b1);
        step("wr_ch1");
        steps("pulse3", 11);

        write(2, 0, 1'b0);
        step("wr_park");
        steps("park", 6);
        write(2, 2, 1'b0);
        step("wr_unpark");
        steps("sq2", 10);

        ch_en = 4'b0111;
        steps("dis3", 3);
        ch_en = 4'hF;
        steps("reen3", 12);

        write(0, 5, 1'b0);
        step("wr0");
        write(1, 3, 1'b0);
        step("wr1");
        write(2, 4, 1'b0);
        step("wr2");
        write(3, 7, 1'b0);
        step("wr3");
        steps("mix", 9);
        sync = 1'b1;
        step("sync");
        steps("post_sync", 16);

        write(9, 1, 1'b1);
        step("wr_bad");
        steps("post_bad", 6);

        sync = 1'b1;
        write(0, 2, 1'b0);
        step("sync_wr");
        steps("post_sync_wr", 10);

        write(3, 1, 1'b1);
        step("wr_n1");
        steps("pulse1", 4);

        write(0, 5, 1'b0);
        step("wr0_again");
        guard = 0;
        e = exp_vec();
        while (!e[4] && guard < 20) begin
            step("seek_high");
            e = exp_vec();
            guard++;
        end
        check("seek_high.found", 32'(e[4]), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid.clk_out", 32'(clk_out), 32'h0);
        check("rst_mid.tick", 32'(tick), 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold.clk_out", 32'(clk_out), 32'h0);
        rst = 1'b0;
        model_reset();
        steps("post_rst", 22);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
